// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
  localparam int WB_ARB_TIMEOUT_DEFAULT = 15;
  localparam int WB_ARB_NMST = 2;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts granted cycles without ack/err and flags expiry on the TIMEOUT-th one.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic active_i,
  input  logic hit_i,
  output logic expire_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = (active_i & ~hit_i) ? cnt_q + 8'd1 : 8'd0;
  assign expire_o = active_i & (cnt_q == 8'(TIMEOUT - 1));
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_rr_arbiter2.sv
// wb_rr_arbiter2: round-robin arbiter sharing one Wishbone slave between two masters, one transfer per grant.
// Optional watchdog terminating unanswered transfers is compiled in with WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int AW = 2,
  parameter int TIMEOUT = WB_ARB_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [AW-1:0]          m0_adr_i,
  input  logic [3:0]             m0_sel_i,
  input  logic [31:0]            m0_dat_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  output logic                   m0_stall_o,
  output logic [31:0]            m0_dat_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [AW-1:0]          m1_adr_i,
  input  logic [3:0]             m1_sel_i,
  input  logic [31:0]            m1_dat_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   m1_stall_o,
  output logic [31:0]            m1_dat_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_dat_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_stall_i,
  input  logic [31:0]            s_dat_i,
  output logic [WB_ARB_NMST-1:0] gnt_o
);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic req0, req1, own0, own1, owner_cyc, hit, wd_exp, wd_err;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own0 = state_q == ARB_GNT0;
  assign own1 = state_q == ARB_GNT1;
  assign owner_cyc = own0 ? m0_cyc_i : m1_cyc_i;
  assign hit = s_ack_i | s_err_i;
`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .active_i (own0 | own1),
    .hit_i    (hit),
    .expire_o (wd_exp)
  );
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign wd_exp = 1'b0;
`endif
  // A slave ack landing in the expiry cycle wins over the watchdog error.
  assign wd_err = wd_exp & ~s_ack_i;
  // last_q = 1 means m1 was served last, so m0 wins the next tie.
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == ARB_IDLE) begin
      if (req0 & (~req1 | last_q)) begin
        state_d = ARB_GNT0;
        last_d = 1'b0;
      end else if (req1) begin
        state_d = ARB_GNT1;
        last_d = 1'b1;
      end
    end else if (hit | ~owner_cyc | wd_exp) begin
      state_d = ARB_IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  assign s_cyc_o = (own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0) & ~wd_err;
  assign s_stb_o = (own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0) & ~wd_err;
  assign s_we_o = own0 ? m0_we_i : own1 ? m1_we_i : 1'b0;
  assign s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
  assign s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
  assign s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
  assign m0_ack_o = own0 & s_ack_i;
  assign m0_err_o = own0 & (s_err_i | wd_err);
  assign m0_stall_o = own0 ? s_stall_i : req0;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_ack_o = own1 & s_ack_i;
  assign m1_err_o = own1 & (s_err_i | wd_err);
  assign m1_stall_o = own1 ? s_stall_i : req1;
  assign m1_dat_o = own1 ? s_dat_i : '0;
  assign gnt_o = {own1, own0};
endmodule
